// File: rtl/mem_bus_ctl.sv
// PDP-8 memory bus controller: routes CPU read/write strobes to the boot ROM or to an
// asynchronous SRAM with programmable wait states, and returns data with a one-cycle ack.
module mem_bus_ctl #(
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] cpu_addr,
  input  logic [11:0] cpu_data_in,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [11:0] cpu_data_out,
  output logic        cpu_ack,
  output logic        busy,
  output logic [14:0] rom_addr,
  output logic        rom_rd,
  input  logic [11:0] rom_data,
  input  logic        rom_selected,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_data_out,
  input  logic [11:0] ram_data_in,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  localparam logic [3:0] WaitM1 = 4'(RAM_WAIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StRamRd,
    StRamWr,
    StRamRec,
    StDone
  } state_e;

  state_e      r_state;
  logic [14:0] r_addr;
  logic [11:0] r_wdata;
  logic        r_op_rd;
  logic [3:0]  r_cnt;

  assign rom_addr     = r_addr;
  assign ram_addr     = r_addr;
  assign ram_data_out = r_wdata;
  assign busy         = (r_state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_op_rd      <= 1'b0;
      r_cnt        <= '0;
      cpu_data_out <= '0;
      cpu_ack      <= 1'b0;
      rom_rd       <= 1'b0;
      ram_ce_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
    end else begin
      cpu_ack <= 1'b0;
      rom_rd  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cpu_rd || cpu_wr) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_data_in;
            r_op_rd <= cpu_rd;  // read wins when both strobes are high
            r_state <= StDecode;
          end
        end
        StDecode: begin
          if (r_op_rd && rom_selected) begin
            rom_rd       <= 1'b1;
            cpu_data_out <= rom_data;
            cpu_ack      <= 1'b1;
            r_state      <= StDone;
          end else begin
            // Writes always land in SRAM, even inside the ROM window
            ram_ce_n <= 1'b0;
            r_cnt    <= WaitM1;
            if (r_op_rd) begin
              ram_oe_n <= 1'b0;
              r_state  <= StRamRd;
            end else begin
              ram_we_n <= 1'b0;
              r_state  <= StRamWr;
            end
          end
        end
        StRamRd: begin
          if (r_cnt == 4'd0) begin
            cpu_data_out <= ram_data_in;
            ram_ce_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            cpu_ack      <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StRamWr: begin
          if (r_cnt == 4'd0) begin
            ram_we_n <= 1'b1;
            r_state  <= StRamRec;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StRamRec: begin
          ram_ce_n <= 1'b1;
          cpu_ack  <= 1'b1;
          r_state  <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctl.sv
// Scoreboard bench for mem_bus_ctl: ROM/SRAM models, ack latency and data checks,
// plus two extra instances for the shortest and longest wait-state settings.
module tb_mem_bus_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] cpu_addr = '0;
  logic [11:0] cpu_data_in = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [11:0] cpu_data_out;
  logic        cpu_ack, busy, rom_rd, rom_selected;
  logic [14:0] rom_addr, ram_addr;
  logic [11:0] rom_data, ram_data_out, ram_data_in;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  logic [11:0] w1_dout, w15_dout, w1_rdo, w15_rdo;
  logic        w1_ack, w15_ack, w1_busy, w15_busy, w1_rom_rd, w15_rom_rd;
  logic [14:0] w1_rom_addr, w15_rom_addr, w1_ram_addr, w15_ram_addr;
  logic        w1_ce_n, w1_oe_n, w1_we_n, w15_ce_n, w15_oe_n, w15_we_n;

  logic        rom_active = 1'b1;
  logic [11:0] mem [0:32767];

  always #5 clk = ~clk;

  mem_bus_ctl #(.RAM_WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .busy(busy), .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .rom_selected(rom_selected), .ram_addr(ram_addr), .ram_data_out(ram_data_out),
    .ram_data_in(ram_data_in), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  mem_bus_ctl #(.RAM_WAIT(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_data_out(w1_dout), .cpu_ack(w1_ack),
    .busy(w1_busy), .rom_addr(w1_rom_addr), .rom_rd(w1_rom_rd), .rom_data(12'o0),
    .rom_selected(1'b0), .ram_addr(w1_ram_addr), .ram_data_out(w1_rdo),
    .ram_data_in(12'o6543), .ram_ce_n(w1_ce_n), .ram_oe_n(w1_oe_n), .ram_we_n(w1_we_n)
  );

  mem_bus_ctl #(.RAM_WAIT(15)) u_dut_w15 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_data_out(w15_dout), .cpu_ack(w15_ack),
    .busy(w15_busy), .rom_addr(w15_rom_addr), .rom_rd(w15_rom_rd), .rom_data(12'o0),
    .rom_selected(1'b0), .ram_addr(w15_ram_addr), .ram_data_out(w15_rdo),
    .ram_data_in(12'o6543), .ram_ce_n(w15_ce_n), .ram_oe_n(w15_oe_n), .ram_we_n(w15_we_n)
  );

  // Boot ROM model: window 07400..07577 while active
  assign rom_selected = rom_active && (rom_addr >= 15'o07400) && (rom_addr <= 15'o07577);
  always_comb begin
    rom_data = 12'o0;
    case (rom_addr)
      15'o07400: rom_data = 12'o7240;
      15'o07410: rom_data = 12'o3410;
      default:   rom_data = 12'o0;
    endcase
  end

  assign ram_data_in = mem[ram_addr];
  always @(negedge clk) if (!ram_ce_n && !ram_we_n) mem[ram_addr] = ram_data_out;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  typedef struct {
    logic [11:0] data;
    int          cyc;
  } exp_t;
  exp_t        q[$];
  logic [11:0] last_rd = 12'o0;

  int n_rom_rd = 0, n_ce = 0, n_we = 0, n_rec = 0, n_ack = 0;
  int ack1_cyc = -1, ack15_cyc = -1;
  logic [11:0] ack1_data, ack15_data;

  always @(negedge clk) begin
    if (!reset) begin
      if (rom_rd) n_rom_rd++;
      if (!ram_ce_n) n_ce++;
      if (!ram_we_n) n_we++;
      if (!ram_ce_n && ram_we_n && ram_oe_n) n_rec++;
      if (w1_ack) begin ack1_cyc = cyc; ack1_data = w1_dout; end
      if (w15_ack) begin ack15_cyc = cyc; ack15_data = w15_dout; end
      if (cpu_ack) begin
        n_ack++;
        if (q.size() == 0) begin
          chk("spurious ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack data", {20'd0, cpu_data_out}, {20'd0, e.data});
          chk("ack cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [14:0] addr,
                       input logic [11:0] wd, input logic [11:0] rdata, input int lat,
                       input bit expect_ack, output int t_drive);
    exp_t e;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_data_in = wd;
    t_drive = cyc;
    if (expect_ack) begin
      if (rd) last_rd = rdata;
      e.data = last_rd;
      e.cyc  = cyc + lat;
      q.push_back(e);
    end
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !busy && !w1_busy && !w15_busy) done = 1;
    end
    if (!done) chk("idle timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t, c_rom, c_ce, c_we, c_rec, c_ack;
    for (int i = 0; i < 32768; i++) mem[i] = 12'o0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst data_out", {20'd0, cpu_data_out}, 32'd0);
    chk("rst ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst rom_rd", {31'd0, rom_rd}, 32'd0);
    chk("rst rom_addr", {17'd0, rom_addr}, 32'd0);
    chk("rst ram_addr", {17'd0, ram_addr}, 32'd0);
    chk("rst ram_dout", {20'd0, ram_data_out}, 32'd0);
    chk("rst strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    @(negedge clk) reset = 1'b0;

    // ROM read
    c_rom = n_rom_rd; c_ce = n_ce;
    issue(1'b1, 1'b0, 15'o07400, 12'o0, 12'o7240, 2, 1'b1, t);
    wait_idle();
    chk("rom rd pulses", n_rom_rd - c_rom, 32'd1);
    chk("rom rd ce_n", n_ce - c_ce, 32'd0);

    // SRAM write then read-back
    c_we = n_we; c_rec = n_rec;
    issue(1'b0, 1'b1, 15'o00010, 12'o1234, 12'o0, 5, 1'b1, t);
    wait_idle();
    chk("wr we_n low cycles", n_we - c_we, 32'd2);
    chk("wr recovery cycles", n_rec - c_rec, 32'd1);
    issue(1'b1, 1'b0, 15'o00010, 12'o0, 12'o1234, 4, 1'b1, t);
    wait_idle();

    // Write into shadowed ROM window
    c_rom = n_rom_rd;
    issue(1'b0, 1'b1, 15'o07410, 12'o5555, 12'o0, 5, 1'b1, t);
    wait_idle();
    chk("shadow wr rom_rd", n_rom_rd - c_rom, 32'd0);
    chk("shadow wr mem", {20'd0, mem[15'o07410]}, {20'd0, 12'o5555});
    issue(1'b1, 1'b0, 15'o07410, 12'o0, 12'o3410, 2, 1'b1, t);
    wait_idle();
    rom_active = 1'b0;
    issue(1'b1, 1'b0, 15'o07410, 12'o0, 12'o5555, 4, 1'b1, t);
    wait_idle();

    // Both strobes: read wins
    mem[15'o00020] = 12'o0707;
    c_we = n_we;
    issue(1'b1, 1'b1, 15'o00020, 12'o1111, 12'o0707, 4, 1'b1, t);
    wait_idle();
    chk("rd+wr no we_n", n_we - c_we, 32'd0);
    chk("rd+wr mem kept", {20'd0, mem[15'o00020]}, {20'd0, 12'o0707});

    // Strobe while busy is ignored
    c_ack = n_ack;
    issue(1'b1, 1'b0, 15'o00010, 12'o0, 12'o1234, 4, 1'b1, t);
    @(negedge clk) cpu_wr = 1'b1;
    @(negedge clk) cpu_wr = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("busy strobe acks", n_ack - c_ack, 32'd1);

    // Reset in the middle of a write
    c_ack = n_ack;
    issue(1'b0, 1'b1, 15'o00030, 12'o4444, 12'o0, 0, 1'b0, t);
    @(negedge clk);
    chk("we_n low pre-reset", {31'd0, ram_we_n}, 32'd0);
    reset = 1'b1;
    #1;
    chk("abort strobes", {30'd0, ram_we_n, ram_ce_n}, 32'd3);
    chk("abort busy", {31'd0, busy}, 32'd0);
    last_rd = 12'o0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort no ack", n_ack - c_ack, 32'd0);
    issue(1'b1, 1'b0, 15'o00010, 12'o0, 12'o1234, 4, 1'b1, t);
    wait_idle();

    // Wait-state extremes
    ack1_cyc = -1; ack15_cyc = -1;
    issue(1'b1, 1'b0, 15'o00020, 12'o0, 12'o0707, 4, 1'b1, t);
    wait_idle();
    chk("w1 rd lat", ack1_cyc - t, 32'd3);
    chk("w15 rd lat", ack15_cyc - t, 32'd17);
    chk("w1 rd data", {20'd0, ack1_data}, {20'd0, 12'o6543});
    chk("w15 rd data", {20'd0, ack15_data}, {20'd0, 12'o6543});
    ack1_cyc = -1; ack15_cyc = -1;
    issue(1'b0, 1'b1, 15'o00040, 12'o0001, 12'o0, 5, 1'b1, t);
    wait_idle();
    chk("w1 wr lat", ack1_cyc - t, 32'd4);
    chk("w15 wr lat", ack15_cyc - t, 32'd18);
    chk("w15 wr data held", {20'd0, ack15_data}, {20'd0, 12'o6543});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
